// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the single-issue MIPS datapath.
// Optional feature: define ILLEGAL_TRAP_EN to trap on unknown instructions (sticky `illegal` flag).
module multi_cycle_ctrl #(
  parameter int ST_W = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       dm_ready,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       dm_req,
  output logic [3:0] ALUOp,
  output logic [1:0] EXTOp,
  output logic [2:0] NPCOp,
  output logic       ALUSrc_Sel,
  output logic [1:0] RegDst_Sel,
  output logic [1:0] GRFWD_Sel,
  output logic       instr_done,
  output logic       illegal
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_JR    = 6'b001000;

  typedef enum logic [ST_W-1:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  state_t state_r;
  state_t state_next_s;

  logic is_add_s, is_sub_s, is_sll_s, is_jr_s, is_lw_s, is_sw_s;
  logic is_ori_s, is_lui_s, is_beq_s, is_j_s, is_jal_s;
  logic is_ralu_s, legal_s;
  logic irwrite_s, pcwrite_s, regwrite_s, memwrite_s, dm_req_s;
`ifdef ILLEGAL_TRAP_EN
  logic illegal_set_s;
  logic illegal_r;
`endif

  // Instruction decode from the IR fields
  always_comb begin
    is_add_s = 1'b0;
    is_sub_s = 1'b0;
    is_sll_s = 1'b0;
    is_jr_s  = 1'b0;
    is_lw_s  = 1'b0;
    is_sw_s  = 1'b0;
    is_ori_s = 1'b0;
    is_lui_s = 1'b0;
    is_beq_s = 1'b0;
    is_j_s   = 1'b0;
    is_jal_s = 1'b0;
    case (Op)
      OP_RTYPE: begin
        case (Funct)
          FN_ADD:  is_add_s = 1'b1;
          FN_SUB:  is_sub_s = 1'b1;
          FN_SLL:  is_sll_s = 1'b1;
          FN_JR:   is_jr_s  = 1'b1;
          default: is_add_s = 1'b0;
        endcase
      end
      OP_LW:   is_lw_s  = 1'b1;
      OP_SW:   is_sw_s  = 1'b1;
      OP_ORI:  is_ori_s = 1'b1;
      OP_LUI:  is_lui_s = 1'b1;
      OP_BEQ:  is_beq_s = 1'b1;
      OP_J:    is_j_s   = 1'b1;
      OP_JAL:  is_jal_s = 1'b1;
      default: is_add_s = 1'b0;
    endcase
  end

  assign is_ralu_s = is_add_s | is_sub_s | is_sll_s;
  assign legal_s   = is_ralu_s | is_jr_s | is_lw_s | is_sw_s | is_ori_s |
                     is_lui_s | is_beq_s | is_j_s | is_jal_s;

  // Selects are purely decoded and stay valid in every state
  assign ALUOp = (is_sub_s || is_beq_s) ? 4'b0001 :
                 is_ori_s               ? 4'b0010 :
                 is_lui_s               ? 4'b0011 :
                 is_sll_s               ? 4'b0100 : 4'b0000;
  assign EXTOp      = (is_lw_s || is_sw_s || is_beq_s) ? 2'b01 : 2'b00;
  assign NPCOp      = (is_j_s || is_jal_s)   ? 3'b010 :
                      is_jr_s                ? 3'b011 :
                      (is_beq_s && Zero)     ? 3'b001 : 3'b000;
  assign ALUSrc_Sel = is_lw_s | is_sw_s | is_ori_s | is_lui_s;
  assign RegDst_Sel = is_jal_s ? 2'b10 : (is_ralu_s ? 2'b01 : 2'b00);
  assign GRFWD_Sel  = is_jal_s ? 2'b10 : (is_lw_s ? 2'b01 : 2'b00);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and per-state strobes
  always_comb begin
    state_next_s = state_r;
    irwrite_s    = 1'b0;
    pcwrite_s    = 1'b0;
    regwrite_s   = 1'b0;
    memwrite_s   = 1'b0;
    dm_req_s     = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    illegal_set_s = 1'b0;
`endif
    case (state_r)
      S_FETCH: begin
        irwrite_s    = 1'b1;
        state_next_s = S_DECODE;
      end
      S_DECODE: begin
        if (is_j_s || is_jr_s) begin
          pcwrite_s    = 1'b1;
          state_next_s = S_FETCH;
        end else if (is_jal_s) begin
          state_next_s = S_WB;
        end else if (!legal_s) begin
`ifdef ILLEGAL_TRAP_EN
          illegal_set_s = 1'b1;
          state_next_s  = S_TRAP;
`else
          // Unknown instruction retires as a NOP (NPCOp decodes to PC+4)
          pcwrite_s    = 1'b1;
          state_next_s = S_FETCH;
`endif
        end else begin
          state_next_s = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_beq_s) begin
          pcwrite_s    = 1'b1;
          state_next_s = S_FETCH;
        end else if (is_lw_s || is_sw_s) begin
          state_next_s = S_MEM;
        end else begin
          state_next_s = S_WB;
        end
      end
      S_MEM: begin
        dm_req_s   = 1'b1;
        memwrite_s = is_sw_s;
        if (dm_ready) begin
          if (is_sw_s) begin
            pcwrite_s    = 1'b1;
            state_next_s = S_FETCH;
          end else begin
            state_next_s = S_WB;
          end
        end else begin
          state_next_s = S_MEM;
        end
      end
      S_WB: begin
        regwrite_s   = 1'b1;
        pcwrite_s    = 1'b1;
        state_next_s = S_FETCH;
      end
      S_TRAP:  state_next_s = S_TRAP;
      default: state_next_s = S_FETCH;
    endcase
  end

  // Strobes are masked while reset is held low so an abandoned instruction commits nothing
  assign IRWrite    = reset & irwrite_s;
  assign PCWrite    = reset & pcwrite_s;
  assign RegWrite   = reset & regwrite_s;
  assign MemWrite   = reset & memwrite_s;
  assign dm_req     = reset & dm_req_s;
  assign instr_done = reset & pcwrite_s;

`ifdef ILLEGAL_TRAP_EN
  // Sticky unknown-instruction flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      illegal_r <= 1'b0;
    end else if (illegal_set_s) begin
      illegal_r <= 1'b1;
    end else begin
      illegal_r <= illegal_r;
    end
  end
  assign illegal = illegal_r;
`else
  assign illegal = 1'b0;
`endif

endmodule
